// File: rtl/stream_select.sv
// stream_select: registered N-channel pixel-stream selector with SOF-aligned switching.
// Define STREAM_SELECT_TEST_PATTERN_EN to add a pattern generator as virtual channel CH_NUM.
module stream_select #(
  parameter int DATA_W       = 16,
  parameter int CH_NUM       = 4,
  parameter int SEL_W        = 3,
  parameter int TP_FRAME_LEN = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM*DATA_W-1:0] data_in,
  input  logic [CH_NUM-1:0]        valid_in,
  input  logic [CH_NUM-1:0]        sof_in,
  input  logic [SEL_W-1:0]         data_select,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic                     sof_out,
  output logic [SEL_W-1:0]         sel_act,
  output logic                     frame_abort,
  output logic [15:0]              frame_cnt
);

`ifdef STREAM_SELECT_TEST_PATTERN_EN
  localparam int NCH = CH_NUM + 1;
`else
  localparam int NCH = CH_NUM;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    WAIT_SOF
  } state_t;

  logic [DATA_W-1:0] ch_data [NCH];
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_sof;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    assign ch_data[k] = data_in[k*DATA_W +: DATA_W];
  end

`ifdef STREAM_SELECT_TEST_PATTERN_EN
  logic [DATA_W-1:0] tp_data_q;

  // Free-running pattern: beat index within its frame doubles as pixel data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_data_q <= '0;
    end else if (tp_data_q == DATA_W'(TP_FRAME_LEN - 1)) begin
      tp_data_q <= '0;
    end else begin
      tp_data_q <= tp_data_q + 1'b1;
    end
  end

  assign ch_data[CH_NUM]       = tp_data_q;
  assign ch_valid              = {1'b1, valid_in};
  assign ch_sof                = {tp_data_q == '0, sof_in};
`else
  assign ch_valid = valid_in;
  assign ch_sof   = sof_in;
`endif

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_sof;
  logic              s_hit;

  // Out-of-range selects match no channel and so never produce a hit.
  always_comb begin
    s_data  = '0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (data_select == SEL_W'(k)) begin
        s_data  = ch_data[k];
        s_valid = ch_valid[k];
        s_sof   = ch_sof[k];
      end
    end
  end

  assign s_hit = s_valid & s_sof;

  state_t            state_q;
  logic              in_frame_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              sof_q;
  logic [SEL_W-1:0]  sel_q;
  logic              abort_q;
  logic [15:0]       cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_frame_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      sel_q      <= '0;
      abort_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      abort_q <= 1'b0;
      unique case (state_q)
        PASS: begin
          if (data_select == sel_q) begin
            valid_q <= s_valid;
            sof_q   <= s_hit;
            if (s_valid) data_q <= s_data;
            if (s_hit) begin
              cnt_q      <= cnt_q + 16'd1;
              in_frame_q <= 1'b1;
            end
          end else begin
            abort_q <= in_frame_q;
            if (s_hit) begin
              sel_q      <= data_select;
              data_q     <= s_data;
              valid_q    <= 1'b1;
              sof_q      <= 1'b1;
              cnt_q      <= cnt_q + 16'd1;
              in_frame_q <= 1'b1;
            end else begin
              state_q    <= WAIT_SOF;
              valid_q    <= 1'b0;
              sof_q      <= 1'b0;
              in_frame_q <= 1'b0;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          sof_q   <= 1'b0;
          if (s_hit) begin
            state_q    <= PASS;
            sel_q      <= data_select;
            data_q     <= s_data;
            valid_q    <= 1'b1;
            sof_q      <= 1'b1;
            cnt_q      <= cnt_q + 16'd1;
            in_frame_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign sof_out     = sof_q;
  assign sel_act     = sel_q;
  assign frame_abort = abort_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_stream_select.sv
// tb_stream_select: randomized and directed checks of stream_select
// against a frame-lock reference model.
module tb_stream_select;
  localparam int DW  = 16;
  localparam int CH  = 4;
  localparam int SW  = 3;
  localparam int TPL = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CH*DW-1:0] data_in = '0;
  logic [CH-1:0]    valid_in = '0;
  logic [CH-1:0]    sof_in = '0;
  logic [SW-1:0]    data_select = '0;
  logic [DW-1:0]    data_out;
  logic             valid_out;
  logic             sof_out;
  logic [SW-1:0]    sel_act;
  logic             frame_abort;
  logic [15:0]      frame_cnt;

  int checks = 0;
  int errors = 0;

  stream_select #(
    .DATA_W(DW), .CH_NUM(CH), .SEL_W(SW), .TP_FRAME_LEN(TPL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
    .data_select(data_select),
    .data_out(data_out), .valid_out(valid_out), .sof_out(sof_out),
    .sel_act(sel_act), .frame_abort(frame_abort), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Model: either locked onto a channel or waiting for a SOF.
  bit          m_lock;
  logic [DW-1:0] m_d;
  logic        m_v, m_sof, m_abort;
  logic [SW-1:0] m_ch;
  logic [15:0] m_cnt;
  int          m_tp;

  wire [DW+SW+18:0] got = {data_out, valid_out, sof_out, sel_act,
                           frame_abort, frame_cnt};
  wire [DW+SW+18:0] exp = {m_d, m_v, m_sof, m_ch, m_abort, m_cnt};

  task automatic model_reset();
    m_lock = 0; m_d = '0; m_v = 0; m_sof = 0;
    m_ch = '0; m_abort = 0; m_cnt = '0; m_tp = 0;
  endtask

  task automatic cycle();
    int s;
    logic [DW-1:0] d;
    logic v, f;
    bit hit;
    if (rst_n) begin
      s = int'(data_select);
      d = '0; v = 0; f = 0;
      if (s < CH) begin
        d = data_in[s*DW +: DW];
        v = valid_in[s];
        f = sof_in[s];
      end
`ifdef STREAM_SELECT_TEST_PATTERN_EN
      else if (s == CH) begin
        d = DW'(m_tp); v = 1; f = (m_tp == 0);
      end
`endif
      hit = v && f;
      m_abort = 0;
      if (m_lock && s == int'(m_ch)) begin
        m_v = v;
        m_sof = hit;
        if (v) m_d = d;
        if (hit) m_cnt = m_cnt + 16'd1;
      end else begin
        if (m_lock) m_abort = 1;
        m_v = 0; m_sof = 0;
        m_lock = 0;
        if (hit) begin
          m_lock = 1; m_ch = SW'(s); m_d = d;
          m_v = 1; m_sof = 1; m_cnt = m_cnt + 16'd1;
        end
      end
      m_tp = (m_tp + 1) % TPL;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    data_in = '0; valid_in = '0; sof_in = '0;
  endtask

  task automatic drive(input int ch, input logic v, input logic f,
                       input logic [DW-1:0] d);
    valid_in[ch] = v;
    sof_in[ch] = f;
    data_in[ch*DW +: DW] = d;
  endtask

  task automatic rand_inputs(input int sofpct);
    for (int k = 0; k < CH; k++) begin
      valid_in[k] = ($urandom_range(0, 3) != 0);
      sof_in[k] = ($urandom_range(0, 99) < sofpct);
      data_in[k*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_vals dut=%h exp=0", got);
    end
    do_reset();
    data_select = '0;
    repeat (2) cycle();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_idle dut=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_single_frame();
    data_select = '0;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b1, i == 1, DW'(i));
      cycle();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL frame_beat%0d dut=%h exp=%h", i, got, exp);
      end
      if (i == 1) begin
        checks++;
        if ({data_out, valid_out, sof_out, frame_cnt} !== {16'h0001, 2'b11, 16'd1}) begin
          errors++;
          $display("FAIL frame_first d=%h v=%b s=%b cnt=%0d exp 0001/1/1/1",
                   data_out, valid_out, sof_out, frame_cnt);
        end
      end
    end
    clear_inputs();
    cycle();
    checks++;
    if ({valid_out, data_out} !== {1'b0, 16'h0004}) begin
      errors++;
      $display("FAIL frame_hold v=%b d=%h exp 0/0004", valid_out, data_out);
    end
  endtask

  task automatic test_mid_switch();
    int aborts = 0;
    int gaps = 0;
    drive(0, 1'b1, 1'b0, 16'h0100);
    data_select = 3'd2;
    for (int i = 0; i < 6; i++) begin
      drive(2, i != 0, i == 5, (i == 5) ? 16'h2222 : DW'($urandom));
      cycle();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL switch_cyc%0d dut=%h exp=%h", i, got, exp);
      end
      if (frame_abort) aborts++;
      if (!valid_out) gaps++;
    end
    checks++;
    if (aborts != 1 || gaps != 5) begin
      errors++;
      $display("FAIL switch_gap aborts=%0d gaps=%0d exp 1/5", aborts, gaps);
    end
    checks++;
    if ({data_out, valid_out, sof_out, sel_act} !== {16'h2222, 2'b11, 3'd2}) begin
      errors++;
      $display("FAIL switch_sof d=%h v=%b s=%b sel=%0d exp 2222/1/1/2",
               data_out, valid_out, sof_out, sel_act);
    end
    drive(2, 1'b1, 1'b0, 16'h2223);
    cycle();
  endtask

  task automatic test_coincident();
    drive(2, 1'b1, 1'b0, 16'h2224);
    drive(1, 1'b1, 1'b1, 16'hABCD);
    data_select = 3'd1;
    cycle();
    checks++;
    if ({data_out, valid_out, sof_out, sel_act} !== {16'hABCD, 2'b11, 3'd1}) begin
      errors++;
      $display("FAIL coinc d=%h v=%b s=%b sel=%0d exp abcd/1/1/1",
               data_out, valid_out, sof_out, sel_act);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL coinc_model dut=%h exp=%h", got, exp);
    end
    drive(1, 1'b1, 1'b0, 16'hABCE);
    cycle();
    checks++;
    if ({valid_out, data_out} !== {1'b1, 16'hABCE}) begin
      errors++;
      $display("FAIL coinc_next v=%b d=%h exp 1/abce", valid_out, data_out);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] cnt0;
    int bad = 0;
    cnt0 = m_cnt;
    data_select = 3'd5;
    for (int i = 0; i < 20; i++) begin
      rand_inputs(50);
      cycle();
      if (i > 0 && (valid_out !== 1'b0 || frame_cnt !== cnt0)) bad++;
      if (got !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL oor_hold bad=%0d v=%b cnt=%0d exp 0/%0d",
               bad, valid_out, frame_cnt, cnt0);
    end
    data_select = 3'd0;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b0, DW'($urandom));
      cycle();
      checks++;
      if (valid_out !== 1'b0 || got !== exp) begin
        errors++;
        $display("FAIL oor_wait v=%b dut=%h exp=%h", valid_out, got, exp);
      end
    end
    drive(0, 1'b1, 1'b1, 16'h0C0C);
    cycle();
    checks++;
    if ({data_out, valid_out, sof_out, sel_act} !== {16'h0C0C, 2'b11, 3'd0}) begin
      errors++;
      $display("FAIL oor_resume d=%h v=%b s=%b sel=%0d exp 0c0c/1/1/0",
               data_out, valid_out, sof_out, sel_act);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs(10);
      if ($urandom_range(0, 15) == 0) data_select = SW'($urandom_range(0, 7));
      cycle();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_cyc%0d dut=%h exp=%h", i, got, exp);
      end
    end
  endtask

`ifdef STREAM_SELECT_TEST_PATTERN_EN
  task automatic test_pattern();
    do_reset();
    data_select = SW'(CH);
    for (int i = 0; i < 2 * TPL + 1; i++) begin
      cycle();
      checks++;
      if ({data_out, valid_out, sof_out} !== {DW'(i % TPL), 1'b1, i % TPL == 0}
          || got !== exp) begin
        errors++;
        $display("FAIL pattern_beat%0d d=%h v=%b s=%b exp d=%h", i,
                 data_out, valid_out, sof_out, DW'(i % TPL));
      end
    end
  endtask
`endif

  task automatic test_wrap_reset();
    clear_inputs();
    data_select = 3'd0;
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
      drive(0, 1'b1, 1'b1, DW'(i));
      cycle();
    end
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_pre cnt=%h exp ffff", frame_cnt);
    end
    drive(0, 1'b1, 1'b1, 16'h5A5A);
    cycle();
    checks++;
    if (frame_cnt !== 16'h0000 || got !== exp) begin
      errors++;
      $display("FAIL wrap_zero cnt=%h dut=%h exp=%h", frame_cnt, got, exp);
    end
    drive(0, 1'b1, 1'b0, 16'h5A5B);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL async_reset dut=%h exp=0", got);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b0, DW'($urandom));
      cycle();
      checks++;
      if (valid_out !== 1'b0 || got !== exp) begin
        errors++;
        $display("FAIL post_reset v=%b dut=%h exp=%h", valid_out, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_mid_switch();
    test_coincident();
    test_out_of_range();
    test_random();
`ifdef STREAM_SELECT_TEST_PATTERN_EN
    test_pattern();
`endif
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_select.md
# stream_select

Registered N-channel pixel-stream selector with frame-aligned switching. It sits between the CMOS capture channels and the DDR3 write path. It forwards one channel's 16-bit pixel beats with one cycle of latency. A change of `data_select` takes effect only when the newly selected channel presents a start-of-frame beat, so frames written to memory never start mid-frame.

## Interface
- `DATA_W`, 16: pixel word width.
- `CH_NUM`, 4: number of input channels, minimum 2.
- `SEL_W`, 3: select width; must satisfy 2^SEL_W > CH_NUM.
- `TP_FRAME_LEN`, 1024: beats per test-pattern frame (only used with the macro).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in CH_NUM*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- `valid_in` in CH_NUM: per-channel beat valid.
- `sof_in` in CH_NUM: per-channel start-of-frame marker, qualified by `valid_in`.
- `data_select` in SEL_W: requested channel, sampled every clock.
- `data_out` out DATA_W: forwarded pixel.
- `valid_out` out 1: `data_out` is valid.
- `sof_out` out 1: forwarded beat is the first beat of a frame.
- `sel_act` out SEL_W: channel currently being forwarded.
- `frame_abort` out 1: one-cycle pulse when an active frame is truncated by a switch.
- `frame_cnt` out 16: count of `sof_out` beats emitted; wraps at 0xFFFF to 0.

## Operation
- States: IDLE (after reset), PASS, WAIT_SOF. Let `s` be the value of `data_select` sampled at the clock edge.
- **IDLE / WAIT_SOF**
  - `valid_out` is driven to 0.
  - If `s` is in range and `valid_in[s] & sof_in[s]`: `sel_act` <= s, forward that beat with `sof_out` = 1, go to PASS, set in_frame.
  - Otherwise remain in the current state.
- **PASS, `s` == `sel_act`**
  - `data_out`, `valid_out`, `sof_out` <= channel `sel_act` values.
  - `data_out` holds its last value when `valid_out` = 0.
- **PASS, `s` != `sel_act`**
  - If `valid_in[s] & sof_in[s]` in the same cycle: switch immediately and forward that beat.
  - Otherwise go to WAIT_SOF with `valid_out` <= 0.
  - In both cases `frame_abort` <= in_frame. in_frame is set only by the new channel's SOF.
- Out-of-range `s` (>= CH_NUM, macro absent): treated as "no channel".
  - In PASS: go to WAIT_SOF, with `frame_abort` as above.
  - In IDLE/WAIT_SOF: remain, `valid_out` = 0.
- The `frame_cnt` increment and `sof_out` are set in the same registered update.
- `sof_in` without `valid_in` is ignored.
- A beat with `sof_in` on the active channel while in PASS is forwarded normally; it starts a new frame with no abort.

## Timing
- Latency: input beat at edge t appears on outputs after edge t; one register stage, no bubbles in PASS.
- Switch delay: 0 cycles of gap if the new channel's SOF coincides with the select change. Otherwise `valid_out` stays low from the cycle after the change until the new channel's SOF beat is output.
- Reset values:
  - `data_out` = 0, `valid_out` = 0, `sof_out` = 0.
  - `sel_act` = 0, `frame_abort` = 0, `frame_cnt` = 0.
  - State = IDLE, in_frame = 0.
- Reset asserted mid-frame clears everything immediately, with no abort pulse. After release the block waits in IDLE for a SOF.
- `data_select` is a quasi-static control in the `clk` domain; it is not synchronised inside the block.

## Configuration
- `STREAM_SELECT_TEST_PATTERN_EN` defined: an internal pattern generator acts as virtual channel CH_NUM.
  - It produces a valid beat every cycle.
  - Data is a DATA_W-bit counter that resets to 0 at each of its frames.
  - `sof` is asserted on beat 0 of every TP_FRAME_LEN beats.
  - Selecting CH_NUM follows the same SOF-aligned rules as a real channel.
  - The generator free-runs from reset.
- Undefined: no generator logic. `s` = CH_NUM is out of range like any other out-of-range value.

## Test plan
- **Reset, then single frame:** hold `rst_n` = 0, release with `data_select` = 0. Channel 0 sends SOF followed by data 0x0001..0x0004. Required: outputs match one cycle later with `sof_out` = 1 on 0x0001, and `frame_cnt` = 1.
- **Mid-frame switch:** in PASS on ch0 with in_frame = 1, set `data_select` = 2 while ch2 sends its SOF 5 cycles later. Required: `frame_abort` pulses once, `valid_out` = 0 for 5 cycles, then ch2's SOF beat is output and `sel_act` = 2.
- **Coincident switch:** select changes to ch1 on the same cycle that ch1 presents valid+SOF with 0xABCD. Required: next cycle `data_out` = 0xABCD, `sof_out` = 1, no `valid_out` gap.
- **Out-of-range select:** with the macro absent and CH_NUM = 4, set `data_select` = 5. Required: `valid_out` stays 0 indefinitely and `frame_cnt` does not change. Returning to 0 resumes only at ch0's next SOF.
- **Counter wrap and async reset:** preload to `frame_cnt` = 0xFFFF by forcing 65535 SOFs, then send one more SOF. Required: `frame_cnt` = 0. Then assert `rst_n` mid-frame. Required: all outputs are 0 within the same cycle, with no `clk` edge needed.
- **Test pattern (macro defined, TP_FRAME_LEN = 8):** set `data_select` = CH_NUM. Required: the first output is a SOF with `data_out` = 0, followed by 1..7, then the next SOF with 0.
